// File: rtl/imem_if.sv
// imem_if: request/response bus between the fetch unit and a 1-cycle-latency synchronous instruction memory
interface imem_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  modport master (output imem_req, output imem_addr, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation plus a prefetch queue that feeds decode and survives freezes and branch flushes
module fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  imem_if.master      imem,
  output logic [31:0] Ins,
  output logic [31:0] PC,
  output logic        Ins_valid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, last_addr_q, last_addr_d;
  logic          inflight_q, inflight_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   ins_q [DEPTH];
  logic [31:0]   pc4_q [DEPTH];
  logic          pop, push, issue;
  logic [CW:0]   occ;
  // occ counts queued words plus the one in flight, so a request is only issued when its word has a slot
  always_comb begin
    Ins_valid      = rst & (count_q != '0);
    Ins            = Ins_valid ? ins_q[rd_ptr_q] : '0;
    PC             = Ins_valid ? pc4_q[rd_ptr_q] : '0;
    pop            = Ins_valid & ~freeze & ~branch_taken;
    push           = inflight_q & ~branch_taken;
    occ            = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    issue          = rst & ~branch_taken & (occ < (CW+1)'(DEPTH));
    imem.imem_req  = issue;
    imem.imem_addr = rst ? fetch_pc_q : PC_RESET;
    fetch_pc_d     = branch_taken ? branch_addr : issue ? fetch_pc_q + 32'd4 : fetch_pc_q;
    last_addr_d    = issue ? fetch_pc_q : last_addr_q;
    inflight_d     = issue;
    rd_ptr_d       = branch_taken ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d       = branch_taken ? '0 : wr_ptr_q + AW'(push);
    count_d        = branch_taken ? '0 : count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc_q  <= PC_RESET;
      last_addr_q <= PC_RESET;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      last_addr_q <= last_addr_d;
      inflight_q  <= inflight_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst && push) begin
      ins_q[wr_ptr_q] <= imem.imem_rdata;
      pc4_q[wr_ptr_q] <= last_addr_q + 32'd4;
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that produces the `Ins` word and its PC+4 for the decode stage. It drives a 1-cycle-latency synchronous instruction memory and buffers returned words in a small prefetch queue, so a decode-stage hazard stall never drops or repeats a fetch. On a taken branch from the execute stage it flushes all prefetched work and redirects. It sits between instruction memory and the decode stage, replacing the plain PC register plus IF/ID register.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_0000, first fetch address after reset.
- `DEPTH`, 2, prefetch queue entries; power of two, 2..8.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `freeze`  in  1  decode-stage hazard; head entry is held, not consumed.
- `branch_taken`  in  1  execute-stage taken branch; flush and redirect.
- `branch_addr`  in  32  redirect target, valid when `branch_taken`=1.
- `imem_req`  out  1  fetch request this cycle.
- `imem_addr`  out  32  fetch address, valid when `imem_req`=1.
- `imem_rdata`  in  32  instruction word. Valid the cycle after its request. Always returned; no backpressure.
- `Ins`  out  32  head instruction to decode; 32'h0 when queue empty.
- `PC`  out  32  PC+4 of the head instruction; 32'h0 when queue empty.
- `Ins_valid`  out  1  queue non-empty.

## Operation
- State:
  - `fetch_pc` (32b), the next address to request.
  - `inflight` (1b), a request was issued last cycle.
  - Circular queue of DEPTH entries {pc_plus4, ins}, with `rd_ptr`, `wr_ptr` and `count` (0..DEPTH).
- `pop` = `Ins_valid` & ~`freeze` & ~`branch_taken`. Head entry is dropped at the clock edge.
- `push` = `inflight` & ~`branch_taken`. Writes {`imem_addr` of last cycle + 4, `imem_rdata`} at `wr_ptr`. The last-cycle address is held in a register.
- `imem_req` = `rst` & ~`branch_taken` & (`count` + `inflight` − `pop` < DEPTH).
  - Space is pre-reserved for every in-flight word, so push never hits a full queue.
  - `imem_addr` = `fetch_pc`.
  - On issue, `fetch_pc` += 4. Wraps modulo 2^32.
- Simultaneous push and pop: `count` unchanged; both pointers advance. Pointers wrap modulo DEPTH.
- Taken branch in cycle N:
  - No request is issued in cycle N.
  - The word returning in cycle N is discarded.
  - The queue is cleared at the end of N (`count`=0, pointers=0, `inflight`=0).
  - `fetch_pc` ← `branch_addr`.
  - Branch overrides `freeze`, push and pop.
- Output mux: when `count`=0, `Ins` and `PC` are forced to 0. This keeps a bubble harmless if decode ignores `Ins_valid`.
- Reset (`rst`=0 at an edge, including mid-operation):
  - `fetch_pc` ← PC_RESET; `inflight`, `count` and pointers ← 0.
  - The last-address register ← PC_RESET.
  - Any word returned during reset is discarded.
- Output values while in reset and on the first cycle after it: `imem_req`=0 during reset, `imem_addr`=PC_RESET, `Ins`=0, `PC`=0, `Ins_valid`=0.

## Timing
- First cycle with `rst`=1 (cycle 0): `imem_req`=1, `imem_addr`=PC_RESET.
- Word arrives in cycle 1 and is pushed at the end of cycle 1.
- `Ins_valid`=1 in cycle 2 with `PC`=PC_RESET+4. Fetch-to-decode latency is 2 cycles.
- Steady state with `freeze`=0: one request and one valid instruction per cycle, consecutive addresses.
- `freeze` held for K cycles:
  - The head stays constant.
  - Requests stop once `count` + `inflight` = DEPTH. No word is lost or duplicated.
  - After release, consecutive instructions resume with no gap.
- Branch in cycle N: request to `branch_addr` in N+1; `Ins_valid`=0 in N+1 and N+2; target valid in N+3 with `PC`=`branch_addr`+4.
- Branch and `freeze` in the same cycle: behaves as a branch alone.

## Test plan
- Reset release with PC_RESET=0, imem[i]=i*4+0xE000_0000, `freeze`=0 → `imem_addr` 0,4,8… from cycle 0. `Ins_valid` from cycle 2 with `Ins`=0xE000_0000, `PC`=4, then one instruction per cycle.
- `freeze`=1 for 5 cycles while `Ins`=word@8 → `Ins`/`PC` hold 12 for 5 cycles. `imem_req` drops after queue+inflight reach DEPTH. Following cycles show words @12, @16 with no gap.
- `branch_taken`=1, `branch_addr`=0x100 in cycle N → `imem_req`=0 in N. Request for 0x100 in N+1. `Ins_valid`=0 in N+1 and N+2. `Ins`=word@0x100, `PC`=0x104 in N+3. Stale words never appear.
- `branch_taken` and `freeze` both 1 in the same cycle with a full queue → flush; same timing as the previous scenario.
- `fetch_pc` = 0xFFFF_FFFC → next request address 0x0000_0000. `PC` for the wrapped entry is 0x0000_0000.
- `rst`=0 for one cycle mid-stream with a full queue → `Ins_valid`=0 and `Ins`=0 next cycle. Fetch restarts at PC_RESET. The in-flight word is discarded.
